// File: rtl/i2c_target_regmap.sv
// i2c_target_regmap: system-clocked I2C target bridging a filtered I2C bus to a regmap port
module i2c_target_regmap #(
    parameter logic [6:0] SLAVE_ID   = 7'h24,
    parameter int         ADDR_BYTES = 1,
    parameter int         FILTER_LEN = 3,
    parameter bit         AUTO_INC   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    scl_in,
    input  logic                    sda_in,
    output logic                    sda_oe,
    output logic                    i2c_active,
    output logic                    wr_en,
    output logic                    rd_en,
    output logic [8*ADDR_BYTES-1:0] addr,
    output logic [7:0]              wdata,
    output logic                    wr_strobe,
    output logic                    rd_strobe,
    input  logic [7:0]              rdata
);
    localparam int AW = 8 * ADDR_BYTES;

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, ADDR_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t st, st_nxt;
    logic [1:0] s1, s2, filt, filt_d;
    logic [3:0] fcnt [2];
    logic scl_f, sda_f, scl_rise, scl_fall, sda_rise, sda_fall, start, stop, bus_ev;
    logic [3:0] bitcnt;
    logic [1:0] abyte;
    logic ack_ph, nack, rw, rd_pend;
    logic [7:0] sh, tx, byte_in;
    logic [AW-1:0] abuf, addr_full;
    logic rx_st, ack_st, byte_done, ack_end, id_match, last_abyte;

    // Synchronise both lines and only accept a new level after FILTER_LEN stable samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '1;
            s2      <= '1;
            filt    <= '1;
            filt_d  <= '1;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            s1     <= {sda_in, scl_in};
            s2     <= s1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) fcnt[i] <= '0;
                else if (fcnt[i] == 4'(FILTER_LEN - 1)) begin
                    filt[i] <= s2[i];
                    fcnt[i] <= '0;
                end else fcnt[i] <= fcnt[i] + 4'd1;
            end
        end
    end

    assign scl_f    = filt[0];
    assign sda_f    = filt[1];
    assign scl_rise = filt[0] & ~filt_d[0];
    assign scl_fall = ~filt[0] & filt_d[0];
    assign sda_rise = filt[1] & ~filt_d[1];
    assign sda_fall = ~filt[1] & filt_d[1];
    assign start    = sda_fall & scl_f;
    assign stop     = sda_rise & scl_f;
    assign bus_ev   = start | stop;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else st <= st_nxt;
    end

    // Next-state: bus conditions override everything, then per-state byte/ack progress
    always_comb begin
        st_nxt = st;
        if (start) st_nxt = DEV_ADDR;
        else if (stop) st_nxt = IDLE;
        else begin
            case (st)
                DEV_ADDR: if (byte_done) st_nxt = id_match ? DEV_ACK : IGNORE;
                DEV_ACK:  if (ack_end) st_nxt = rw ? RD_DATA : REG_ADDR;
                REG_ADDR: if (byte_done) st_nxt = ADDR_ACK;
                ADDR_ACK: if (ack_end) st_nxt = (abyte == 2'(ADDR_BYTES)) ? WR_DATA : REG_ADDR;
                WR_DATA:  if (byte_done) st_nxt = WR_ACK;
                WR_ACK:   if (ack_end) st_nxt = WR_DATA;
                RD_DATA:  if (scl_fall && bitcnt == 4'd8) st_nxt = RD_ACK;
                RD_ACK:   if (scl_fall && ack_ph) st_nxt = nack ? IGNORE : RD_DATA;
                default:  ;
            endcase
        end
    end

    // Output decode: per-clk control conditions consumed by the datapath
    always_comb begin
        rx_st      = (st == DEV_ADDR) || (st == REG_ADDR) || (st == WR_DATA);
        ack_st     = (st == DEV_ACK) || (st == ADDR_ACK) || (st == WR_ACK);
        byte_in    = {sh[6:0], sda_f};
        byte_done  = rx_st && scl_rise && bitcnt == 4'd7;
        ack_end    = ack_st && scl_fall && ack_ph;
        id_match   = byte_in[7:1] == SLAVE_ID;
        last_abyte = abyte == 2'(ADDR_BYTES - 1);
        addr_full  = (abuf << 8) | AW'(byte_in);
    end

    // Datapath: shift registers, address, strobes and the open-drain SDA driver
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_oe     <= 1'b0;
            i2c_active <= 1'b0;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            wr_strobe  <= 1'b0;
            rd_strobe  <= 1'b0;
            bitcnt     <= '0;
            abyte      <= '0;
            ack_ph     <= 1'b0;
            nack       <= 1'b0;
            rw         <= 1'b0;
            rd_pend    <= 1'b0;
            sh         <= '0;
            tx         <= '0;
            abuf       <= '0;
        end else begin
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            if (wr_strobe && AUTO_INC) addr <= addr + AW'(1);
            if (bus_ev) begin
                sda_oe     <= 1'b0;
                i2c_active <= start;
                wr_en      <= 1'b0;
                rd_en      <= 1'b0;
                bitcnt     <= '0;
                abyte      <= '0;
                ack_ph     <= 1'b0;
                rd_pend    <= 1'b0;
            end else begin
                if (rx_st && scl_rise) begin
                    sh     <= byte_in;
                    bitcnt <= bitcnt + 4'd1;
                end
                if (byte_done && st == DEV_ADDR && id_match) begin
                    rw    <= sda_f;
                    wr_en <= ~sda_f;
                    rd_en <= sda_f;
                end
                if (byte_done && st == REG_ADDR) begin
                    abyte <= abyte + 2'd1;
                    abuf  <= addr_full;
                    if (last_abyte) addr <= addr_full;
                end
                if (byte_done && st == WR_DATA) begin
                    wdata     <= byte_in;
                    wr_strobe <= 1'b1;
                end
                if (ack_st && scl_fall) begin
                    sda_oe <= ~ack_ph;
                    ack_ph <= ~ack_ph;
                    if (ack_ph) bitcnt <= '0;
                end
                if (ack_end && st == DEV_ACK && rw) rd_pend <= 1'b1;
                if (st == RD_DATA && scl_rise) bitcnt <= bitcnt + 4'd1;
                if (st == RD_DATA && scl_fall) begin
                    tx     <= tx << 1;
                    sda_oe <= (bitcnt == 4'd8) ? 1'b0 : ~tx[6];
                end
                if (st == RD_ACK && scl_rise) begin
                    nack   <= sda_f;
                    ack_ph <= 1'b1;
                end
                if (st == RD_ACK && scl_fall && ack_ph) begin
                    ack_ph <= 1'b0;
                    if (!nack) begin
                        rd_pend <= 1'b1;
                        if (AUTO_INC) addr <= addr + AW'(1);
                    end
                end
                if (rd_pend) begin
                    rd_pend   <= 1'b0;
                    rd_strobe <= 1'b1;
                    tx        <= rdata;
                    sda_oe    <= ~rdata[7];
                    bitcnt    <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_regmap.sv
// tb_i2c_target_regmap: directed I2C master with a strobe scoreboard over three target configurations
`timescale 1ns/1ps
module tb_i2c_target_regmap;
    localparam int Q = 10;

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [7:0]  d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mscl = 1'b1;
    logic msda = 1'b1;
    int   sel = 1;
    int   checks = 0;
    int   errors = 0;
    bit   oe_seen = 1'b0;
    exp_t sb[$];
    exp_t e_m;

    always #5 clk = ~clk;

    logic scl1, sda1, oe1, act1, wen1, ren1, ws1, rs1;
    logic [7:0] a1, wd1, rd1;
    logic scl2, sda2, oe2, act2, wen2, ren2, ws2, rs2;
    logic [15:0] a2;
    logic [7:0] wd2, rd2;
    logic scl3, sda3, oe3, act3, wen3, ren3, ws3, rs3;
    logic [7:0] a3, wd3, rd3;

    assign scl1 = (sel == 1) ? mscl : 1'b1;
    assign sda1 = (sel == 1) ? (msda & ~oe1) : 1'b1;
    assign scl2 = (sel == 2) ? mscl : 1'b1;
    assign sda2 = (sel == 2) ? (msda & ~oe2) : 1'b1;
    assign scl3 = (sel == 3) ? mscl : 1'b1;
    assign sda3 = (sel == 3) ? (msda & ~oe3) : 1'b1;
    assign rd1 = a1 ^ 8'h5A;
    assign rd2 = a2[15:8] + a2[7:0];
    assign rd3 = a3 ^ 8'hA5;

    i2c_target_regmap u1 (
        .clk(clk), .rst_n(rst_n), .scl_in(scl1), .sda_in(sda1), .sda_oe(oe1),
        .i2c_active(act1), .wr_en(wen1), .rd_en(ren1), .addr(a1), .wdata(wd1),
        .wr_strobe(ws1), .rd_strobe(rs1), .rdata(rd1)
    );

    i2c_target_regmap #(.ADDR_BYTES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .scl_in(scl2), .sda_in(sda2), .sda_oe(oe2),
        .i2c_active(act2), .wr_en(wen2), .rd_en(ren2), .addr(a2), .wdata(wd2),
        .wr_strobe(ws2), .rd_strobe(rs2), .rdata(rd2)
    );

    i2c_target_regmap #(.AUTO_INC(1'b0)) u3 (
        .clk(clk), .rst_n(rst_n), .scl_in(scl3), .sda_in(sda3), .sda_oe(oe3),
        .i2c_active(act3), .wr_en(wen3), .rd_en(ren3), .addr(a3), .wdata(wd3),
        .wr_strobe(ws3), .rd_strobe(rs3), .rdata(rd3)
    );

    logic m_ws, m_rs, m_oe, bus_sda;
    logic [15:0] m_a;
    logic [7:0] m_wd;

    always_comb begin
        m_ws    = (sel == 1) ? ws1 : (sel == 2) ? ws2 : ws3;
        m_rs    = (sel == 1) ? rs1 : (sel == 2) ? rs2 : rs3;
        m_oe    = (sel == 1) ? oe1 : (sel == 2) ? oe2 : oe3;
        m_a     = (sel == 1) ? {8'h00, a1} : (sel == 2) ? a2 : {8'h00, a3};
        m_wd    = (sel == 1) ? wd1 : (sel == 2) ? wd2 : wd3;
        bus_sda = (sel == 1) ? sda1 : (sel == 2) ? sda2 : sda3;
    end

    // Monitor: every strobe of the selected target is matched against the oldest expectation
    always @(negedge clk) begin
        if (m_oe) oe_seen = 1'b1;
        if (m_ws || m_rs) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL strobe: unexpected wr=%0d addr=%h data=%h, required none", m_ws, m_a, m_wd);
            end else begin
                e_m = sb.pop_front();
                if (m_ws !== e_m.wr || m_a !== e_m.a || (e_m.wr && m_wd !== e_m.d)) begin
                    errors++;
                    $display("FAIL strobe: got wr=%0d addr=%h data=%h, required wr=%0d addr=%h data=%h",
                             m_ws, m_a, m_wd, e_m.wr, e_m.a, e_m.d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic expect_strobe(input bit wr, input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.wr = wr;
        e.a  = a;
        e.d  = d;
        sb.push_back(e);
    endtask

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        w(Q); msda = 1'b0; w(Q); mscl = 1'b0;
    endtask

    task automatic i2c_rstart;
        w(Q); msda = 1'b1; w(Q); mscl = 1'b1; w(Q); msda = 1'b0; w(Q); mscl = 1'b0;
    endtask

    task automatic i2c_stop;
        w(Q); msda = 1'b0; w(Q); mscl = 1'b1; w(Q); msda = 1'b1; w(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            w(Q); msda = b[7-i]; w(Q); mscl = 1'b1; w(2*Q); mscl = 1'b0;
        end
    endtask

    task automatic ack_phase(input logic ack_req, input string name);
        w(Q); msda = 1'b1; w(Q); mscl = 1'b1; w(Q);
        chk(name, bus_sda, ack_req);
        w(Q); mscl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack_req, input string name);
        send_bits(b, 8);
        ack_phase(ack_req, name);
    endtask

    task automatic read_byte(input logic mack, input logic [7:0] exp, input string name);
        logic [7:0] d;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            w(Q); msda = 1'b1; w(Q); mscl = 1'b1; w(Q); d = {d[6:0], bus_sda}; w(Q); mscl = 1'b0;
        end
        chk(name, d, exp);
        w(Q); msda = mack; w(Q); mscl = 1'b1; w(Q);
        chk({name, "_sda_released"}, m_oe, 0);
        w(Q); mscl = 1'b0;
    endtask

    initial begin
        w(4); rst_n = 1'b1; w(4);
        chk("rst_sda_oe", oe1, 0);
        chk("rst_active", act1, 0);
        chk("rst_en", {wen1, ren1}, 0);
        chk("rst_addr", a1, 0);
        chk("rst_wdata", wd1, 0);
        chk("rst_strobes", {ws1, rs1}, 0);

        // single byte write
        expect_strobe(1'b1, 16'h0010, 8'hA5);
        i2c_start;
        send_byte(8'h48, 1'b0, "t1_id_ack");
        chk("t1_active", act1, 1);
        chk("t1_wr_en", {wen1, ren1}, 2'b10);
        send_byte(8'h10, 1'b0, "t1_reg_ack");
        send_byte(8'hA5, 1'b0, "t1_data_ack");
        i2c_stop;
        chk("t1_addr_after", a1, 8'h11);
        chk("t1_active_after", act1, 0);

        // burst write across the 8-bit wrap
        expect_strobe(1'b1, 16'h00FE, 8'h01);
        expect_strobe(1'b1, 16'h00FF, 8'h02);
        expect_strobe(1'b1, 16'h0000, 8'h03);
        i2c_start;
        send_byte(8'h48, 1'b0, "t2_id_ack");
        send_byte(8'hFE, 1'b0, "t2_reg_ack");
        send_byte(8'h01, 1'b0, "t2_d0_ack");
        send_byte(8'h02, 1'b0, "t2_d1_ack");
        send_byte(8'h03, 1'b0, "t2_d2_ack");
        i2c_stop;
        chk("t2_addr_after", a1, 8'h01);

        // foreign device address is ignored
        oe_seen = 1'b0;
        i2c_start;
        send_byte(8'h50, 1'b1, "t3_id_nack");
        chk("t3_en", {wen1, ren1}, 0);
        send_byte(8'h10, 1'b1, "t3_reg_nack");
        i2c_stop;
        chk("t3_sda_never_driven", oe_seen, 0);
        chk("t3_addr_kept", a1, 8'h01);

        // SCL glitch inside the register byte, then a partial data byte cut by STOP
        expect_strobe(1'b1, 16'h0030, 8'h77);
        i2c_start;
        send_byte(8'h48, 1'b0, "t4_id_ack");
        send_bits(8'h30, 3);
        w(Q); mscl = 1'b1; w(2); mscl = 1'b0;
        send_bits(8'h80, 5);
        ack_phase(1'b0, "t4_reg_ack");
        send_byte(8'h77, 1'b0, "t4_data_ack");
        send_bits(8'hC0, 4);
        i2c_stop;
        chk("t4_active_after", act1, 0);
        chk("t4_wr_en_after", wen1, 0);
        chk("t4_addr_after", a1, 8'h31);

        // random read with a two-byte register address
        sel = 2;
        expect_strobe(1'b0, 16'h1234, 8'h00);
        expect_strobe(1'b0, 16'h1235, 8'h00);
        expect_strobe(1'b0, 16'h1236, 8'h00);
        i2c_start;
        send_byte(8'h48, 1'b0, "t5_id_ack");
        send_byte(8'h12, 1'b0, "t5_rhi_ack");
        send_byte(8'h34, 1'b0, "t5_rlo_ack");
        i2c_rstart;
        send_byte(8'h49, 1'b0, "t5_rid_ack");
        chk("t5_rd_en", {wen2, ren2}, 2'b01);
        read_byte(1'b0, 8'h46, "t5_b0");
        read_byte(1'b0, 8'h47, "t5_b1");
        read_byte(1'b1, 8'h48, "t5_b2");
        chk("t5_rd_en_held", ren2, 1);
        i2c_stop;
        chk("t5_rd_en_after", ren2, 0);
        chk("t5_active_after", act2, 0);

        // read without auto-increment, then reset in the middle of a read byte
        sel = 3;
        repeat (4) expect_strobe(1'b0, 16'h0020, 8'h00);
        i2c_start;
        send_byte(8'h48, 1'b0, "t6_id_ack");
        send_byte(8'h20, 1'b0, "t6_reg_ack");
        i2c_rstart;
        send_byte(8'h49, 1'b0, "t6_rid_ack");
        read_byte(1'b0, 8'h85, "t6_b0");
        read_byte(1'b0, 8'h85, "t6_b1");
        read_byte(1'b1, 8'h85, "t6_b2");
        i2c_stop;
        chk("t6_addr_held", a3, 8'h20);
        i2c_start;
        send_byte(8'h49, 1'b0, "t6_id2_ack");
        w(Q); msda = 1'b1; w(Q); mscl = 1'b1; w(Q);
        chk("t6_bit7", bus_sda, 1);
        w(Q); mscl = 1'b0; w(2*Q);
        chk("t6_bit6_driven", oe3, 1);
        chk("t6_rd_en_pre_reset", ren3, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_sda_oe", oe3, 0);
        chk("t6_rst_flags", {act3, wen3, ren3, ws3, rs3}, 0);
        chk("t6_rst_addr", a3, 0);
        chk("t6_rst_wdata", wd3, 0);
        w(4);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2c_target_regmap.md
Name: i2c_target_regmap

Overview:
- Next-generation I2C slave for the regmap, clocked from the system clk rather than from SCL.
- Oversamples and glitch-filters SCL/SDA, and supports 1- or 2-byte register addresses.
- Auto-increment can be switched on or off; repeated START is supported for random reads.
- Sits between the pad open-drain buffers and the regmap read/write port.

Parameters:
- SLAVE_ID, 7'h24, 7-bit device address matched after START.
- ADDR_BYTES, 1, register address width in bytes (legal 1 or 2); addr width AW = 8*ADDR_BYTES.
- FILTER_LEN, 3, consecutive equal synchronised samples required before a filtered line changes (legal 1..15).
- AUTO_INC, 1, 1 = addr increments after every data byte; 0 = addr holds.

Ports:
- clk  input  1  system clock, at least 20x SCL frequency.
- rst_n  input  1  reset, asynchronous, active-low.
- scl_in  input  1  raw SCL pad input.
- sda_in  input  1  raw SDA pad input.
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- i2c_active  output  1  high from START to STOP.
- wr_en  output  1  ID matched, write transfer in progress.
- rd_en  output  1  ID matched, read transfer in progress.
- addr  output  AW  current register address.
- wdata  output  8  write data, valid while wr_strobe is high.
- wr_strobe  output  1  one-clk write pulse.
- rd_strobe  output  1  one-clk pulse; rdata is captured on this same clk edge.
- rdata  input  8  regmap read data for addr, combinational from addr.

Behaviour:
- Reset values: sda_oe=0, i2c_active=0, wr_en=0, rd_en=0, addr=0, wdata=0, wr_strobe=0, rd_strobe=0; FSM=IDLE; filtered lines=1.
- Input path: 2-FF synchroniser, then filter. Filtered value toggles after FILTER_LEN consecutive samples differing from the current filtered value.
- Edge detection: scl_rise / scl_fall / sda_rise / sda_fall are one-clk pulses derived from the filtered lines.
- START = sda_fall while filtered scl=1. STOP = sda_rise while filtered scl=1.
- START or STOP, from any state, aborts the current byte; no strobe is issued for a partial byte.
- START → DEV_ADDR, bit count cleared, i2c_active=1. This covers repeated START too; addr is retained.
- STOP → IDLE; i2c_active, wr_en, rd_en cleared; sda_oe=0 on the next clk.
- Bit timing: bits are sampled on scl_rise, MSB first. sda_oe changes only on the clk after scl_fall.
- FSM states: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- DEV_ADDR: 8 bits captured. If [7:1]==SLAVE_ID → DEV_ACK, sda_oe=1 for the 9th clock.
  - R/W=0: set wr_en → REG_ADDR, byte index 0.
  - R/W=1: set rd_en, pulse rd_strobe on the 9th scl_fall → RD_DATA.
  - Mismatch → IGNORE, sda released (NACK), wait for START/STOP.
- REG_ADDR: receive ADDR_BYTES bytes, each ACKed (ADDR_ACK), MSB byte first.
  - addr is loaded only once all ADDR_BYTES bytes are received: the full address is loaded on the 8th scl_rise of the last byte.
  - Then → WR_DATA.
- WR_DATA: 8th scl_rise → wdata loaded and wr_strobe pulsed (with current addr) on the following clk. ACK driven in WR_ACK.
  - If AUTO_INC, addr increments on the clk after the wr_strobe pulse.
  - Further bytes repeat.
- RD_DATA: shift register loaded from rdata at rd_strobe; MSB driven after that scl_fall, subsequent bits on each scl_fall.
  - sda_oe = ~bit (open-drain).
  - After the 8th bit, sda released for RD_ACK.
- RD_ACK: master bit sampled on 9th scl_rise.
  - ACK(0): on 9th scl_fall, addr increments if AUTO_INC, rd_strobe pulses one clk later with the new addr, → RD_DATA.
  - NACK(1): → IGNORE (sda released, rd_en held until STOP/START).
- Address arithmetic: increment wraps modulo 2^AW (8'hFF→8'h00, 16'hFFFF→16'h0000).
- Simultaneous START and scl edge in one clk: START has priority.
- Reset mid-transfer releases SDA immediately (asynchronous).

Test Plan:
- Write 1 byte, ADDR_BYTES=1: START, 0x48, 0x10, 0xA5, STOP → 3 ACKs; one wr_strobe with addr=0x10, wdata=0xA5; addr=0x11 afterwards; i2c_active low after STOP.
- Burst write wrap, AUTO_INC=1: START, 0x48, 0xFE, 0x01, 0x02, 0x03, STOP → wr_strobe at addr 0xFE, 0xFF, 0x00 with data 0x01, 0x02, 0x03.
- Random read, ADDR_BYTES=2: START, 0x48, 0x12, 0x34; repeated START, 0x49; master ACK, ACK, NACK; STOP.
  - Required: rd_strobe at addr 0x1234, 0x1235, 0x1236; SDA bits match rdata MSB-first; SDA released on the master-NACK clock; exactly three rd_strobes.
- Wrong ID: START, 0x50, 0x10, STOP → sda_oe never asserted; no strobes; wr_en=rd_en=0.
- Glitch and abort, FILTER_LEN=3: 2-clk SCL glitch mid-byte → no bit counted. Then STOP after 4 data bits → no wr_strobe, FSM IDLE.
- AUTO_INC=0 read of 3 bytes from 0x20 → all rd_strobes at addr 0x20. Then assert rst_n low during RD_DATA → sda_oe=0 the same cycle, all outputs return to reset values.
